// File: rtl/imem_fetch_ctrl.sv
// Fetch sequencer: owns the PC, captures instruction words into a small FIFO, and
// presents them to IF/ID with valid/ready. Optional counters are built under FETCH_PERF_CNT_EN.
module imem_fetch_ctrl #(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       DATA_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter int unsigned       DEPTH     = 2,
  parameter logic [DATA_W-1:0] HALT_WORD = DATA_W'(32'hFC00_0000)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_instr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              halted,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_stall,
`endif
  output logic              busy
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_STALL  = 2'd2,
    S_HALTED = 2'd3
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] instr_mem [DEPTH];
  logic [ADDR_W-1:0] pc_mem    [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr_nx;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_nx;
  logic              pop;
  logic              push;
  logic              full;
  logic              flush;
  logic              is_halt;

  assign imem_addr = pc;
  assign full      = (count == CNT_W'(DEPTH));
  assign pop       = out_valid && out_ready;
  assign flush     = redirect && (state != S_IDLE);
  assign push      = (state == S_FETCH) && !redirect && (!full || pop);
  assign is_halt   = (imem_instr == HALT_WORD);
  assign rd_ptr_nx = rd_ptr + PTR_W'(1);
  assign count_nx  = count + CNT_W'(push) - CNT_W'(pop);

  // Sequencer state, PC, FIFO storage and registered head outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      pc        <= RESET_PC;
      count     <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      out_valid <= 1'b0;
      out_instr <= '0;
      out_pc    <= '0;
      halted    <= 1'b0;
      busy      <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        instr_mem[i] <= '0;
        pc_mem[i]    <= '0;
      end
    end else if (flush) begin
      // Redirect outranks push/pop: drop everything and refetch from the word-aligned target.
      state     <= S_FETCH;
      pc        <= redirect_pc & ~ADDR_W'(3);
      count     <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      out_valid <= 1'b0;
      halted    <= 1'b0;
      busy      <= 1'b1;
    end else begin
      if (push) begin
        instr_mem[wr_ptr] <= imem_instr;
        pc_mem[wr_ptr]    <= pc;
        wr_ptr            <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr_nx;
      end
      count     <= count_nx;
      out_valid <= (count_nx != '0);

      // Head tracks the next entry; it keeps its last value once the FIFO empties.
      if (pop && (count > CNT_W'(1))) begin
        out_instr <= instr_mem[rd_ptr_nx];
        out_pc    <= pc_mem[rd_ptr_nx];
      end else if (push && ((count == '0) || (pop && (count == CNT_W'(1))))) begin
        out_instr <= imem_instr;
        out_pc    <= pc;
      end

      unique case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_FETCH;
            busy  <= 1'b1;
          end
        end
        S_FETCH: begin
          if (push) begin
            if (is_halt) begin
              state  <= S_HALTED;
              halted <= 1'b1;
              busy   <= 1'b0;
            end else begin
              pc <= pc + ADDR_W'(4);
            end
          end else begin
            state <= S_STALL;
          end
        end
        S_STALL: begin
          if (pop) begin
            state <= S_FETCH;
          end
        end
        S_HALTED: begin
        end
        default: begin
        end
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // Pushed-word and stalled-cycle counters, free-running modulo 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
    end else begin
      if (push) begin
        perf_fetched <= perf_fetched + 32'd1;
      end
      if ((state == S_STALL) || ((state == S_FETCH) && full && !pop)) begin
        perf_stall <= perf_stall + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: program-order scoreboard for every IF/ID acceptance,
// plus directed latency, stall, redirect, halt, PC-wrap and reset checks.
module tb_imem_fetch_ctrl;

  localparam logic [31:0] HALT = 32'hFC00_0000;

  logic        clk = 1'b0;
  logic        rst_n, start, out_ready, redirect;
  logic [31:0] redirect_pc, imem_addr, imem_instr, out_instr, out_pc;
  logic        out_valid, halted, busy;

  logic        t_start, t_ready, t_redirect;
  logic [31:0] t_redirect_pc, t_addr, t_imem, t_instr, t_pc;
  logic        t_valid, t_halted, t_busy;

  logic [31:0] mem [64];

  always #5 clk = ~clk;

  assign imem_instr = mem[imem_addr[7:2]];
  assign t_imem     = mem[t_addr[7:2]];

  imem_fetch_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .redirect(redirect), .redirect_pc(redirect_pc), .halted(halted), .busy(busy)
  );

  imem_fetch_ctrl #(.RESET_PC(32'hFFFF_FFF8)) u_top (
    .clk(clk), .rst_n(rst_n), .start(t_start), .imem_addr(t_addr), .imem_instr(t_imem),
    .out_valid(t_valid), .out_ready(t_ready), .out_instr(t_instr), .out_pc(t_pc),
    .redirect(t_redirect), .redirect_pc(t_redirect_pc), .halted(t_halted), .busy(t_busy)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   total = 0;
  int   bad   = 0;
  bit   running = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Program order from pc0: sequential words until (and including) a halt word.
  task automatic build(input logic [31:0] pc0);
    logic [31:0] p;
    exp_t        x;
    p = pc0;
    for (int k = 0; k < 150; k++) begin
      x.pc    = p;
      x.instr = mem[p[7:2]];
      q.push_back(x);
      if (x.instr == HALT) break;
      p = p + 32'd4;
    end
  endtask

  always @(negedge rst_n) begin
    q.delete();
    running = 1'b0;
  end

  // Monitor: every accepted head must be the next instruction in program order.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL pop_unexpected: got pc %h with nothing expected", out_pc);
        end else begin
          e = q.pop_front();
          chk("pop_pc", 64'(out_pc), 64'(e.pc));
          chk("pop_instr", 64'(out_instr), 64'(e.instr));
        end
      end
      if (redirect && running) begin
        q.delete();
        build(redirect_pc & ~32'd3);
      end
      if (start && !running) begin
        running = 1'b1;
        build(32'h0);
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; redirect = 1'b0; out_ready = 1'b0; t_start = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    t_ready = 1'b1; t_redirect = 1'b0; t_redirect_pc = '0; redirect_pc = '0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h2400_0000 | 32'(i);
    rst_n = 1'b0; start = 1'b0; redirect = 1'b0; out_ready = 1'b0; t_start = 1'b0;

    @(negedge clk);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_addr", 64'(imem_addr), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_halted", 64'(halted), 64'd0);
    chk("rst_out_pc", 64'(out_pc), 64'd0);
    chk("rst_out_instr", 64'(out_instr), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Streaming fetch with IF/ID always ready.
    out_ready = 1'b1;
    pulse_start();
    @(negedge clk);
    chk("start_n1_addr", 64'(imem_addr), 64'd0);
    chk("start_n1_valid", 64'(out_valid), 64'd0);
    chk("start_n1_busy", 64'(busy), 64'd1);
    @(negedge clk);
    chk("start_n2_valid", 64'(out_valid), 64'd1);
    chk("start_n2_pc", 64'(out_pc), 64'd0);
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      chk("stream_valid", 64'(out_valid), 64'd1);
      chk("stream_pc", 64'(out_pc), 64'(32'(i) * 32'd4));
    end

    // Fill the FIFO, then reset mid-fetch.
    @(posedge clk); #1 out_ready = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("full_before_rst", 64'(out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 64'(out_valid), 64'd0);
    chk("async_rst_addr", 64'(imem_addr), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_valid", 64'(out_valid), 64'd0);
    chk("idle_addr", 64'(imem_addr), 64'd0);

    // Back-pressure from start: two pushes then stall at pc 8.
    pulse_start();
    repeat (5) @(negedge clk);
    chk("stall_addr", 64'(imem_addr), 64'h8);
    chk("stall_busy", 64'(busy), 64'd1);
    chk("stall_valid", 64'(out_valid), 64'd1);
    chk("stall_head", 64'(out_pc), 64'd0);
    @(posedge clk); #1 out_ready = 1'b1;
    repeat (6) @(posedge clk);

    // Redirect with a full FIFO to an unaligned target.
    #1 out_ready = 1'b0;
    repeat (4) @(posedge clk);
    #1 redirect = 1'b1; redirect_pc = 32'h0000_0013;
    @(posedge clk); #1 redirect = 1'b0;
    @(negedge clk);
    chk("redir_valid", 64'(out_valid), 64'd0);
    chk("redir_addr", 64'(imem_addr), 64'h10);
    @(negedge clk);
    chk("redir_n2_valid", 64'(out_valid), 64'd1);
    chk("redir_n2_pc", 64'(out_pc), 64'h10);
    @(posedge clk); #1 out_ready = 1'b1;
    repeat (5) @(posedge clk);

    // Halt word at address 12, then redirect back to 0.
    #1;
    do_reset();
    mem[3] = HALT;
    out_ready = 1'b1;
    pulse_start();
    repeat (8) @(negedge clk);
    chk("halt_halted", 64'(halted), 64'd1);
    chk("halt_busy", 64'(busy), 64'd0);
    chk("halt_addr", 64'(imem_addr), 64'hC);
    chk("halt_valid", 64'(out_valid), 64'd0);
    chk("halt_drained", 64'(q.size()), 64'd0);
    @(posedge clk); #1 redirect = 1'b1; redirect_pc = 32'h0;
    @(posedge clk); #1 redirect = 1'b0;
    @(negedge clk);
    chk("resume_halted", 64'(halted), 64'd0);
    chk("resume_busy", 64'(busy), 64'd1);
    chk("resume_addr", 64'(imem_addr), 64'd0);
    repeat (8) @(posedge clk);

    // PC wrap at the top of the address space.
    #1 t_start = 1'b1;
    @(posedge clk); #1 t_start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("wrap_valid", 64'(t_valid), 64'd1);
    chk("wrap_pc0", 64'(t_pc), 64'hFFFF_FFF8);
    chk("wrap_instr0", 64'(t_instr), 64'(mem[62]));
    @(negedge clk);
    chk("wrap_pc1", 64'(t_pc), 64'hFFFF_FFFC);
    @(negedge clk);
    chk("wrap_pc2", 64'(t_pc), 64'h0);
    chk("wrap_instr2", 64'(t_instr), 64'(mem[0]));

    // Randomized ready/redirect traffic over a program with sparse halt words.
    @(posedge clk); #1;
    do_reset();
    for (int i = 0; i < 64; i++) mem[i] = ($urandom_range(0, 11) == 0) ? HALT : $urandom;
    out_ready = 1'b1;
    pulse_start();
    for (int c = 0; c < 800; c++) begin
      @(posedge clk); #1;
      out_ready   = ($urandom_range(0, 3) != 0);
      redirect    = ($urandom_range(0, 15) == 0);
      redirect_pc = $urandom;
    end
    @(posedge clk); #1 redirect = 1'b0; out_ready = 1'b1;
    repeat (10) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
